// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store stage: access sizes, FSM states and
// the alignment rule used by both the stage and anything that models it.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // An access is misaligned when the address is not a multiple of its size;
  // a doubleword access on a 32-bit datapath can never be honoured.
  function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                         input logic [1:0] sz,
                                         input int         xlen);
    logic [2:0] low_mask;
    case (sz)
      SZ_BYTE: low_mask = 3'b000;
      SZ_HALF: low_mask = 3'b001;
      SZ_WORD: low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
    return ((sz == SZ_DOUBLE) && (xlen == 32)) || ((addr_lo & low_mask) != 3'b000);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store stage (master) and memory (slave).
// Handshake: a request transfers on a rising edge where dreq_valid and
// dreq_ready are both 1; once dreq_valid rises it stays high with dreq_addr,
// dreq_we, dreq_wdata and dreq_wmask stable until that edge. dreq_valid never
// waits on dreq_ready. A load response is the single cycle with drsp_valid=1,
// drsp_rdata valid in that cycle; responses with no accepted load are ignored.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic              dreq_valid;
  logic              dreq_ready;
  logic              dreq_we;
  logic [ADDR_W-1:0] dreq_addr;
  logic [XLEN-1:0]   dreq_wdata;
  logic [XLEN/8-1:0] dreq_wmask;
  logic              drsp_valid;
  logic [XLEN-1:0]   drsp_rdata;

  modport master (
    output dreq_valid, dreq_we, dreq_addr, dreq_wdata, dreq_wmask,
    input  dreq_ready, drsp_valid, drsp_rdata
  );

  modport slave (
    input  dreq_valid, dreq_we, dreq_addr, dreq_wdata, dreq_wmask,
    output dreq_ready, drsp_valid, drsp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte mask, store data replication and load
// extraction with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] addr_lo,
  input  logic [2:0]                size,
  input  logic [XLEN-1:0]           r2,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN/8-1:0]         wmask,
  output logic [XLEN-1:0]           wdata,
  output logic [XLEN-1:0]           load_data
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;

  // Lane selection for stores and loads from the low address bits.
  always_comb begin
    wmask     = '1;
    wdata     = r2;
    load_data = '0;
    shifted   = rdata >> {addr_lo, 3'b000};
    case (size[1:0])
      SZ_BYTE: begin
        wmask     = NB'(1) << addr_lo;
        wdata     = {NB{r2[7:0]}};
        load_data = size[2] ? XLEN'(shifted[7:0]) : XLEN'($signed(shifted[7:0]));
      end
      SZ_HALF: begin
        wmask     = NB'(3) << addr_lo;
        wdata     = {(XLEN/16){r2[15:0]}};
        load_data = size[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      end
      SZ_WORD: begin
        wmask     = NB'(15) << addr_lo;
        wdata     = {(XLEN/32){r2[31:0]}};
        load_data = size[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      end
      default: begin
        wmask     = '1;
        wdata     = r2;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory pipeline stage: issues M-stage loads/stores on the data bus, stalls
// the pipe until they complete and registers the result into the W stage.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_m,
  input  logic            mem_read_m,
  input  logic            mem_write_m,
  input  logic            reg_write_m,
  input  logic            mem_to_reg_m,
  input  logic [2:0]      size_m,
  input  logic [XLEN-1:0] alu_out_m,
  input  logic [XLEN-1:0] r2_m,
  input  logic [4:0]      rd_m,
  lsu_if.master           dbus,
  output logic            stall_m,
  output logic            valid_w,
  output logic            reg_write_w,
  output logic            mem_to_reg_w,
  output logic            misalign_w,
  output logic [4:0]      rd_w,
  output logic [XLEN-1:0] alu_out_w,
  output logic [XLEN-1:0] read_data_w,
  output lsu_state_e      state_dbg
);

  localparam int K = $clog2(XLEN / 8);

  lsu_state_e        state_q, state_d;
  logic              mem_op, misaligned, aligned_op;
  logic              req_valid, complete, load_done;
  logic [XLEN/8-1:0] wmask;
  logic [XLEN-1:0]   wdata, load_data;

  assign mem_op     = valid_m & (mem_read_m | mem_write_m);
  assign misaligned = mem_op & is_misaligned(alu_out_m[2:0], size_m[1:0], XLEN);
  assign aligned_op = mem_op & ~misaligned;

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo   (alu_out_m[K-1:0]),
    .size      (size_m),
    .r2        (r2_m),
    .rdata     (dbus.drsp_rdata),
    .wmask     (wmask),
    .wdata     (wdata),
    .load_data (load_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, request valid and completion of the current access.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    complete  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_REQ: begin
        if (aligned_op) begin
          req_valid = 1'b1;
          if (dbus.dreq_ready) begin
            if (mem_write_m) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d  = ST_RESP;
            end
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (dbus.drsp_valid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields come straight from the held M inputs, so they stay stable
  // for as long as the stall keeps those inputs frozen.
  assign dbus.dreq_valid = req_valid & ~rst;
  assign dbus.dreq_we    = mem_write_m;
  assign dbus.dreq_addr  = alu_out_m[ADDR_W-1:0];
  assign dbus.dreq_wdata = wdata;
  assign dbus.dreq_wmask = wmask;
  assign stall_m         = aligned_op & ~complete & ~rst;
  assign state_dbg       = state_q;

  // W-stage register: a bubble while stalled, otherwise the M instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || stall_m) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      misalign_w   <= 1'b0;
      rd_w         <= '0;
      alu_out_w    <= '0;
      read_data_w  <= '0;
    end else begin
      valid_w      <= valid_m;
      reg_write_w  <= valid_m & reg_write_m & ~misaligned;
      mem_to_reg_w <= mem_to_reg_m;
      misalign_w   <= misaligned;
      rd_w         <= rd_m;
      alu_out_w    <= alu_out_m;
      read_data_w  <= load_done ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed cases and randomized ops on a 32-bit instance
// against a byte-level reference model, plus a few checks on a 64-bit instance.
module tb_lsu_stage;
  import lsu_pkg::*;

  localparam int W = 73;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 32-bit DUT ----------------
  logic        valid_m, mem_read_m, mem_write_m, reg_write_m, mem_to_reg_m;
  logic [2:0]  size_m;
  logic [31:0] alu_out_m, r2_m;
  logic [4:0]  rd_m;
  logic        stall_m, valid_w, reg_write_w, mem_to_reg_w, misalign_w;
  logic [4:0]  rd_w;
  logic [31:0] alu_out_w, read_data_w;
  lsu_state_e  state_dbg;

  lsu_if #(.XLEN(32), .ADDR_W(32)) bus32 ();

  lsu_stage #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .valid_m(valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .size_m(size_m),
    .alu_out_m(alu_out_m), .r2_m(r2_m), .rd_m(rd_m), .dbus(bus32.master),
    .stall_m(stall_m), .valid_w(valid_w), .reg_write_w(reg_write_w),
    .mem_to_reg_w(mem_to_reg_w), .misalign_w(misalign_w), .rd_w(rd_w),
    .alu_out_w(alu_out_w), .read_data_w(read_data_w), .state_dbg(state_dbg)
  );

  // ---------------- 64-bit DUT ----------------
  logic        valid_m_64, mem_read_m_64, mem_write_m_64, reg_write_m_64, mem_to_reg_m_64;
  logic [2:0]  size_m_64;
  logic [63:0] alu_out_m_64, r2_m_64;
  logic [4:0]  rd_m_64;
  logic        stall_m_64, valid_w_64, reg_write_w_64, mem_to_reg_w_64, misalign_w_64;
  logic [4:0]  rd_w_64;
  logic [63:0] alu_out_w_64, read_data_w_64;
  lsu_state_e  state_dbg_64;

  lsu_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

  lsu_stage #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst),
    .valid_m(valid_m_64), .mem_read_m(mem_read_m_64), .mem_write_m(mem_write_m_64),
    .reg_write_m(reg_write_m_64), .mem_to_reg_m(mem_to_reg_m_64), .size_m(size_m_64),
    .alu_out_m(alu_out_m_64), .r2_m(r2_m_64), .rd_m(rd_m_64), .dbus(bus64.master),
    .stall_m(stall_m_64), .valid_w(valid_w_64), .reg_write_w(reg_write_w_64),
    .mem_to_reg_w(mem_to_reg_w_64), .misalign_w(misalign_w_64), .rd_w(rd_w_64),
    .alu_out_w(alu_out_w_64), .read_data_w(read_data_w_64), .state_dbg(state_dbg_64)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (XLEN=32) ----------------
  function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return (sz == 2'd3) || ((addr % n) != 0);
  endfunction

  function automatic logic [3:0] m_mask(input logic [31:0] addr, input logic [1:0] sz);
    int off, n;
    logic [3:0] m;
    off = addr % 4;
    n   = 1 << sz;
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] r2, input logic [1:0] sz);
    int n;
    logic [31:0] w;
    n = (sz == 2'd3) ? 4 : (1 << sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = r2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [2:0] sz);
    int off, n;
    longint v;
    off = addr % 4;
    n   = 1 << sz[1:0];
    v   = 0;
    for (int j = 0; j < n; j++) v += longint'(rdata[8*(off+j) +: 8]) << (8*j);
    if (!sz[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_w(input string tag, input bit is_load);
    logic [W-1:0] exp, obs;
    exp = exp_q.pop_front();
    obs = {valid_w, reg_write_w, mem_to_reg_w, misalign_w, rd_w, alu_out_w,
           is_load ? read_data_w : 32'h0};
    chk({tag, ":w"}, obs, exp);
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, ":bubble"}, {valid_w, reg_write_w}, 2'b00);
  endtask

  // kind: 0 = non-memory, 1 = load, 2 = store
  task automatic run_op(input string tag, input int kind, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] r2,
                        input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
    bit mis, aligned, is_load, last_req;
    logic [4:0] rd;
    bit rw, m2r;
    rd      = 5'($urandom_range(0, 31));
    rw      = 1'($urandom_range(0, 1));
    m2r     = (kind == 1);
    mis     = (kind != 0) && m_mis(addr, sz[1:0]);
    aligned = (kind != 0) && !mis;
    is_load = aligned && (kind == 1);
    exp_q.push_back({1'b1, rw & !mis, m2r, mis, rd, addr,
                     is_load ? m_load(rdata, addr, sz) : 32'h0});
    @(negedge clk);
    valid_m = 1'b1; mem_read_m = (kind == 1); mem_write_m = (kind == 2);
    reg_write_m = rw; mem_to_reg_m = m2r; size_m = sz; alu_out_m = addr;
    r2_m = r2; rd_m = rd;
    if (!aligned) begin
      bus32.dreq_ready = 1'($urandom_range(0, 1));
      bus32.drsp_valid = 1'($urandom_range(0, 1));
      bus32.drsp_rdata = $urandom;
      #1;
      chk({tag, ":noreq"}, bus32.dreq_valid, 1'b0);
      chk({tag, ":nostall"}, stall_m, 1'b0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c <= rdy_dly; c++) begin
        if (c > 0) @(negedge clk);
        last_req = (c == rdy_dly);
        bus32.dreq_ready = last_req;
        bus32.drsp_valid = 1'($urandom_range(0, 1));
        bus32.drsp_rdata = $urandom;
        #1;
        chk({tag, ":req"}, {bus32.dreq_valid, bus32.dreq_we, bus32.dreq_addr},
            {1'b1, kind == 2, addr});
        chk({tag, ":lanes"}, {bus32.dreq_wmask, bus32.dreq_wdata},
            {m_mask(addr, sz[1:0]), m_wdata(r2, sz[1:0])});
        chk({tag, ":stall_req"}, stall_m, !(last_req && kind == 2));
        @(posedge clk); #1;
        if (!(last_req && kind == 2)) check_bubble(tag);
      end
      if (kind == 1) begin
        for (int c = 0; c <= rsp_dly; c++) begin
          @(negedge clk);
          bus32.dreq_ready = 1'($urandom_range(0, 1));
          bus32.drsp_valid = (c == rsp_dly);
          bus32.drsp_rdata = (c == rsp_dly) ? rdata : $urandom;
          #1;
          chk({tag, ":resp_noreq"}, bus32.dreq_valid, 1'b0);
          chk({tag, ":stall_resp"}, stall_m, c != rsp_dly);
          @(posedge clk); #1;
          if (c != rsp_dly) check_bubble(tag);
        end
      end
    end
    check_w(tag, is_load);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic [2:0] sz;

    rst = 1'b1;
    valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; reg_write_m = 1'b1;
    mem_to_reg_m = 1'b1; size_m = 3'b010; alu_out_m = 32'h100; r2_m = 32'h0; rd_m = 5'd3;
    bus32.dreq_ready = 1'b1; bus32.drsp_valid = 1'b0; bus32.drsp_rdata = '0;
    valid_m_64 = 1'b0; mem_read_m_64 = 1'b0; mem_write_m_64 = 1'b0; reg_write_m_64 = 1'b0;
    mem_to_reg_m_64 = 1'b0; size_m_64 = 3'b000; alu_out_m_64 = '0; r2_m_64 = '0; rd_m_64 = '0;
    bus64.dreq_ready = 1'b0; bus64.drsp_valid = 1'b0; bus64.drsp_rdata = '0;

    // Reset: aligned load presented, yet no request, no stall, W cleared.
    @(negedge clk); #1;
    chk("rst:req_stall", {bus32.dreq_valid, stall_m}, 2'b00);
    chk("rst:w", {valid_w, reg_write_w, mem_to_reg_w, misalign_w, rd_w, alu_out_w, read_data_w},
        '0);
    chk("rst:state", state_dbg, ST_IDLE);
    @(negedge clk);
    rst = 1'b0; valid_m = 1'b0; mem_read_m = 1'b0;

    // Directed cases.
    run_op("lb_0x103", 1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
    chk("lb_0x103:const", read_data_w, 32'hFFFF_FF80);
    run_op("sh_0x102", 2, 3'b001, 32'h102, 32'h0000_BEEF, 32'h0, 0, 0);
    run_op("lw_0x101", 1, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 0);
    chk("lw_0x101:mis", {misalign_w, reg_write_w}, 2'b10);
    run_op("lw_slow", 1, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 3, 1);
    chk("lw_slow:data", read_data_w, 32'hCAFE_F00D);
    run_op("lhu", 1, 3'b101, 32'h302, 32'h0, 32'h8001_0000, 1, 2);
    run_op("sd32", 2, 3'b011, 32'h400, 32'h5555_AAAA, 32'h0, 0, 0);
    run_op("alu", 0, 3'b000, 32'h1357_9BDF, 32'h0, 32'h0, 0, 0);

    // Reset while a load waits for its response; a late response is ignored.
    @(negedge clk);
    valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; size_m = 3'b010;
    alu_out_m = 32'h500; reg_write_m = 1'b1; rd_m = 5'd9;
    bus32.dreq_ready = 1'b1; bus32.drsp_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid:resp", state_dbg, ST_RESP);
    @(negedge clk);
    rst = 1'b1; bus32.dreq_ready = 1'b0;
    #1;
    chk("rst_mid:state", state_dbg, ST_IDLE);
    chk("rst_mid:w", {valid_w, reg_write_w, mem_to_reg_w, misalign_w, rd_w, alu_out_w, read_data_w},
        '0);
    chk("rst_mid:req_stall", {bus32.dreq_valid, stall_m}, 2'b00);
    @(negedge clk);
    rst = 1'b0; valid_m = 1'b0; mem_read_m = 1'b0;
    bus32.drsp_valid = 1'b1; bus32.drsp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stray:stall", {bus32.dreq_valid, stall_m}, 2'b00);
    @(posedge clk); #1;
    chk("stray:state", state_dbg, ST_IDLE);
    chk("stray:w", {valid_w, reg_write_w}, 2'b00);
    run_op("after_rst", 1, 3'b000, 32'h601, 32'h0, 32'h0000_7F00, 0, 1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      sz   = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      run_op($sformatf("rnd%0d", i), kind, sz, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // 64-bit instance: LWU from lane 4 and a byte store replicated to all lanes.
    @(negedge clk);
    valid_m = 1'b0;
    valid_m_64 = 1'b1; mem_read_m_64 = 1'b1; size_m_64 = 3'b110; alu_out_m_64 = 64'h4;
    reg_write_m_64 = 1'b1; rd_m_64 = 5'd7; bus64.dreq_ready = 1'b1;
    #1;
    chk("x64_lwu:req", {bus64.dreq_valid, bus64.dreq_wmask, bus64.dreq_addr},
        {1'b1, 8'hF0, 32'h4});
    @(posedge clk); #1;
    @(negedge clk);
    bus64.dreq_ready = 1'b0; bus64.drsp_valid = 1'b1;
    bus64.drsp_rdata = 64'hF000_0000_0000_0000;
    #1;
    chk("x64_lwu:stall", stall_m_64, 1'b0);
    @(posedge clk); #1;
    chk("x64_lwu:w", {valid_w_64, reg_write_w_64, read_data_w_64},
        {2'b11, 64'h0000_0000_F000_0000});
    @(negedge clk);
    bus64.drsp_valid = 1'b0; mem_read_m_64 = 1'b0; mem_write_m_64 = 1'b1;
    size_m_64 = 3'b000; alu_out_m_64 = 64'h5; r2_m_64 = 64'h1234_5678_9ABC_DEA5;
    bus64.dreq_ready = 1'b1;
    #1;
    chk("x64_sb:req", {bus64.dreq_valid, bus64.dreq_we, bus64.dreq_wmask, stall_m_64},
        {2'b11, 8'h20, 1'b0});
    chk("x64_sb:wdata", bus64.dreq_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    @(posedge clk); #1;
    chk("x64_sb:w", {valid_w_64, misalign_w_64}, 2'b10);
    @(negedge clk);
    valid_m_64 = 1'b0; mem_write_m_64 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the data width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, sets the data-bus address width.
REQ-003 Port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 Ports valid_m, mem_read_m, mem_write_m, reg_write_m and mem_to_reg_m, input, 1 bit each: M-stage instruction valid and controls.
REQ-006 Port size_m, input, 3 bits: funct3; [1:0] 00=byte, 01=half, 10=word, 11=double; [2]=1 means zero-extend.
REQ-007 Ports alu_out_m and r2_m, input, XLEN bits: the effective address/ALU result and the store source.
REQ-008 Port rd_m, input, 5 bits: destination register.
REQ-009 Ports dreq_valid, dreq_we, output, 1 bit: request valid and write enable. Port dreq_ready, input, 1 bit: request accept.
REQ-010 Ports dreq_addr (ADDR_W bits), dreq_wdata (XLEN bits) and dreq_wmask (XLEN/8 bits), output: request address, data and byte mask.
REQ-011 Ports drsp_valid (1 bit) and drsp_rdata (XLEN bits), input: load response.
REQ-012 Port stall_m, output, 1 bit: upstream must hold all M inputs stable while it is high.
REQ-013 Ports valid_w, reg_write_w, mem_to_reg_w and misalign_w (1 bit each), rd_w (5 bits), alu_out_w and read_data_w (XLEN bits), output: registered W-stage outputs.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQ (request pending, not yet accepted) and RESP (load accepted, awaiting response).
REQ-015 A memory op SHALL be valid_m & (mem_read_m | mem_write_m).
REQ-016 An op SHALL be misaligned when its address is not a multiple of the access size; size 11 with XLEN=32 SHALL also count as misaligned.
REQ-017 In IDLE or REQ with an aligned memory op, dreq_valid SHALL be 1, driven combinationally from the M inputs.
REQ-018 Accept SHALL occur on dreq_valid & dreq_ready; a store SHALL complete on accept and a load SHALL move to RESP.
REQ-019 Without accept, the FSM SHALL go to or stay in REQ, and the request fields SHALL stay stable.
REQ-020 In RESP, the load SHALL complete on the cycle drsp_valid=1, and the FSM SHALL return to IDLE.
REQ-021 drsp_valid outside RESP SHALL be ignored.
REQ-022 stall_m SHALL equal (aligned memory op) & ~(completing this cycle).
REQ-023 A non-memory op or a misaligned op SHALL pass to W in 1 cycle with no bus request.
REQ-024 A misaligned op SHALL set misalign_w=1 and force reg_write_w=0.
REQ-025 The W register SHALL load on every edge where stall_m=0; while stall_m=1 it SHALL load a bubble (valid_w=0, reg_write_w=0).
REQ-026 Latency: a load SHALL take at least 2 cycles (accept, then response); a store SHALL take at least 1 cycle.
REQ-027 wmask: byte ops SHALL set one bit at lane addr[k-1:0], where k=log2(XLEN/8).
REQ-028 wmask: half ops SHALL set 2 bits and word ops 4 bits, aligned at the address; double ops SHALL set all bits.
REQ-029 Store data SHALL be replicated across lanes: byte on every byte, half on every half, word on every word.
REQ-030 Load data SHALL be taken from the lane selected by the address and sign-extended to XLEN unless size_m[2]=1, in which case it is zero-extended.
REQ-031 dreq_addr SHALL be the low ADDR_W bits of alu_out_m.

Reset
REQ-032 rst SHALL force state IDLE, all W outputs to 0, and dreq_valid=0 and stall_m=0 during reset.
REQ-033 A reset mid-access SHALL abandon the access; a response arriving after reset SHALL be ignored.

Structure
REQ-034 Shared package lsu_pkg SHALL hold the size encodings and the FSM state enum.
REQ-035 Combinational sub-module lsu_align SHALL perform mask, store-replication and load-extraction logic, parametrised by XLEN.

Verification
REQ-036 XLEN=32, LB, addr 0x103, rdata 0x80FF_0000, ready=1, response 1 cycle later -> read_data_w=0xFFFF_FF80, valid_w=1, stall_m=1 for 1 cycle.
REQ-037 SH, addr 0x102, r2=0x0000_BEEF -> wmask=1100, wdata=0xBEEF_BEEF, 1-cycle completion.
REQ-038 LW, addr 0x101 -> no dreq_valid, misalign_w=1, reg_write_w=0 next cycle.
REQ-039 dreq_ready held 0 for 3 cycles, then LW response after 2 more cycles -> stall_m=1 for 5 cycles, addr stable, 5 bubbles, then valid_w=1.
REQ-040 XLEN=64, LWU, addr 0x4, rdata 0xF000_0000_0000_0000 -> read_data_w=0x0000_0000_F000_0000.
REQ-041 rst asserted in RESP, then a stray drsp_valid -> state IDLE, all W outputs 0, stray response ignored.
